fft8_ctrl: RTL and testbench

FFT8_CTRL -- requirements
Module: fft8_ctrl

---
 rtl/fft_pkg.sv | 38 +++
 rtl/fft8_delay_line.sv | 40 ++++
 rtl/fft8_ctrl.sv | 157 +++++++++++++++
 tb/tb_fft8_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point FFT address controller.
// Holds the FSM state encoding, transform geometry, bus widths, the
// writeback request payload and a bit-reverse helper.
package fft_pkg;

    localparam int unsigned N_PTS   = 8;
    localparam int unsigned LOG2N   = 3;
    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned TW_W    = 2;
    localparam int unsigned STAGE_W = 2;
    localparam int unsigned KCNT_W  = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMP,
        WAIT,
        FIN
    } state_t;

    // One butterfly writeback request travelling through the delay line
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr_a;
        logic [ADDR_W-1:0] addr_b;
    } wb_req_t;

    // Reverse the bit order of a working-RAM address
    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] x);
        logic [ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(ADDR_W); i++) begin
            r[i] = x[int'(ADDR_W) - 1 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft8_delay_line.sv
// Fixed-depth shift register carrying butterfly valid + operand addresses
// from issue to writeback.
// Ports: clk, rst_n (async, active-low); d_valid/d_addr_a/d_addr_b in;
//        q_valid/q_addr_a/q_addr_b out, DEPTH cycles later.
module fft8_delay_line
    import fft_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_addr_a,
    input  logic [ADDR_W-1:0] d_addr_b,
    output logic              q_valid,
    output logic [ADDR_W-1:0] q_addr_a,
    output logic [ADDR_W-1:0] q_addr_b
);

    wb_req_t pipe_q [DEPTH];

    // Shift register; reset flushes in-flight writebacks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= '{valid: d_valid, addr_a: d_addr_a, addr_b: d_addr_b};
            for (int i = 1; i < int'(DEPTH); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_valid  = pipe_q[DEPTH-1].valid;
    assign q_addr_a = pipe_q[DEPTH-1].addr_a;
    assign q_addr_b = pipe_q[DEPTH-1].addr_b;

endmodule

// File: rtl/fft8_ctrl.sv
// Address/sequencing controller for an in-place radix-2 8-point FFT.
// Loads 8 samples, then issues 3 stages of 4 butterflies with a
// PIPE_LAT-cycle drain between stages, then pulses done.
// Ports: clk, rst_n (async, active-low), start, in_valid / in_ready,
//        ld_we/ld_addr (sample load), bf_valid/rd_addr_a/rd_addr_b/tw_addr
//        (butterfly issue), wr_en/wr_addr_a/wr_addr_b (writeback),
//        stage, busy, done.
// Build option: define FFT8_CTRL_BITREV_EN to store loaded samples at
//        bit-reversed addresses; otherwise ld_addr is the load count.
module fft8_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned PIPE_LAT = 2,
    parameter int unsigned N_PTS    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ld_we,
    output logic [2:0] ld_addr,
    output logic       bf_valid,
    output logic [2:0] rd_addr_a,
    output logic [2:0] rd_addr_b,
    output logic [1:0] tw_addr,
    output logic       wr_en,
    output logic [2:0] wr_addr_a,
    output logic [2:0] wr_addr_b,
    output logic [1:0] stage,
    output logic       busy,
    output logic       done
);

    localparam int unsigned WCNT_W = 2;

    if (N_PTS != fft_pkg::N_PTS) begin : g_bad_npts
        $error("fft8_ctrl: N_PTS must be 8");
    end
    if (PIPE_LAT < 1 || PIPE_LAT > 4) begin : g_bad_lat
        $error("fft8_ctrl: PIPE_LAT must be 1..4");
    end

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   n_q, n_d;
    logic [KCNT_W-1:0]   k_q, k_d;
    logic [STAGE_W-1:0]  stage_q, stage_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;

    logic [ADDR_W-1:0]   span, pos, base, addr_a, addr_b;
    logic [TW_W-1:0]     tw;

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            k_q     <= '0;
            stage_q <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            stage_q <= stage_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next-state and counter update
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        stage_d = stage_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                if (in_valid) begin
                    n_d = n_q + ADDR_W'(1);
                    if (n_q == ADDR_W'(N_PTS - 1)) begin
                        state_d = COMP;
                        k_d     = '0;
                        stage_d = '0;
                    end
                end
            end
            COMP: begin
                k_d = k_q + KCNT_W'(1);
                if (k_q == KCNT_W'(3)) begin
                    state_d = WAIT;
                    wcnt_d  = '0;
                end
            end
            WAIT: begin
                // Hold off the next stage until every write of this stage has landed
                wcnt_d = wcnt_q + WCNT_W'(1);
                if (wcnt_q == WCNT_W'(PIPE_LAT - 1)) begin
                    wcnt_d = '0;
                    if (stage_q == STAGE_W'(LOG2N - 1)) begin
                        state_d = FIN;
                    end else begin
                        stage_d = stage_q + STAGE_W'(1);
                        state_d = COMP;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                stage_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Butterfly operand/twiddle addresses for (stage, k)
    always_comb begin
        span   = ADDR_W'(1) << stage_q;
        pos    = ADDR_W'(k_q) & (span - ADDR_W'(1));
        base   = (ADDR_W'(k_q) >> stage_q) << (stage_q + STAGE_W'(1));
        addr_a = base + pos;
        addr_b = addr_a + span;
        tw     = TW_W'(pos << (STAGE_W'(2) - stage_q));
    end

    assign in_ready  = (state_q == LOAD);
    assign ld_we     = in_ready & in_valid;
`ifdef FFT8_CTRL_BITREV_EN
    assign ld_addr   = bitrev(n_q);
`else
    assign ld_addr   = n_q;
`endif
    assign bf_valid  = (state_q == COMP);
    assign rd_addr_a = bf_valid ? addr_a : '0;
    assign rd_addr_b = bf_valid ? addr_b : '0;
    assign tw_addr   = bf_valid ? tw : '0;
    assign stage     = stage_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);

    fft8_delay_line #(
        .DEPTH (PIPE_LAT)
    ) u_dly (
        .clk      (clk),
        .rst_n    (rst_n),
        .d_valid  (bf_valid),
        .d_addr_a (rd_addr_a),
        .d_addr_b (rd_addr_b),
        .q_valid  (wr_en),
        .q_addr_a (wr_addr_a),
        .q_addr_b (wr_addr_b)
    );

endmodule

// File: tb/tb_fft8_ctrl.sv
// Self-checking bench for fft8_ctrl at PIPE_LAT=3.
module tb_fft8_ctrl;

    localparam int unsigned PL = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic       ld_we;
    logic [2:0] ld_addr;
    logic       bf_valid;
    logic [2:0] rd_addr_a;
    logic [2:0] rd_addr_b;
    logic [1:0] tw_addr;
    logic       wr_en;
    logic [2:0] wr_addr_a;
    logic [2:0] wr_addr_b;
    logic [1:0] stage;
    logic       busy;
    logic       done;

    fft8_ctrl #(
        .PIPE_LAT (PL),
        .N_PTS    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .bf_valid  (bf_valid),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .stage     (stage),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  st;
        logic [2:0]  a;
        logic [2:0]  b;
        logic [1:0]  tw;
        int unsigned cyc;
    } bf_t;

    typedef struct packed {
        logic [2:0]  a;
        logic [2:0]  b;
        int unsigned due;
    } wb_t;

    bf_t        bf_q[$];
    wb_t        wb_q[$];
    logic [2:0] ld_q[$];

    int unsigned cyc_n  = 0;
    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned n_fail = 0;

    // Expected butterfly schedule, stage-major, k-minor
    int unsigned exp_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int unsigned exp_b  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int unsigned exp_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
`ifdef FFT8_CTRL_BITREV_EN
    int unsigned exp_ld [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    int unsigned exp_ld [8]  = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc_n);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {7'd0, in_ready, ld_we, ld_addr, bf_valid, rd_addr_a, rd_addr_b,
                tw_addr, wr_en, wr_addr_a, wr_addr_b, stage, busy, done};
    endfunction

    // Scoreboard: pop expected loads/issues/writebacks as the DUT produces them
    task automatic sb_check();
        bf_t e;
        wb_t w;
        if (ld_we === 1'b1) begin
            if (ld_q.size() == 0) chk("ld_unexpected", ld_we, 0);
            else chk("ld_addr", ld_addr, ld_q.pop_front());
        end
        if (bf_valid === 1'b1) begin
            if (bf_q.size() == 0) begin
                chk("bf_unexpected", bf_valid, 0);
            end else begin
                e = bf_q.pop_front();
                chk("bf_addr", {stage, rd_addr_a, rd_addr_b, tw_addr}, {e.st, e.a, e.b, e.tw});
                chk("bf_cycle", cyc_n, e.cyc);
                w.a = e.a;
                w.b = e.b;
                w.due = cyc_n + PL;
                wb_q.push_back(w);
            end
        end
        if (wr_en === 1'b1 || (wb_q.size() > 0 && wb_q[0].due == cyc_n)) begin
            if (wb_q.size() == 0) begin
                chk("wr_unexpected", wr_en, 0);
            end else begin
                w = wb_q.pop_front();
                chk("wr_en", wr_en, 1);
                chk("wr_cycle", cyc_n, w.due);
                chk("wr_addr", {wr_addr_a, wr_addr_b}, {w.a, w.b});
            end
        end
    endtask

    task automatic half();
        @(negedge clk);
        sb_check();
    endtask

    task automatic step_edge();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic run_frame(input bit sparse, input bit poke, input int abort_idx,
                             output bit aborted);
        int          loaded = 0;
        int          issued = 0;
        bit          seen_done = 1'b0;
        int unsigned last_load;
        int unsigned exp_done;
        bf_t         e;
        aborted = 1'b0;

        start = 1'b1;
        half();
        chk("idle_before_start", {busy, in_ready}, 0);
        step_edge();
        start = 1'b0;

        for (int slot = 0; slot < 64 && loaded < 8; slot++) begin
            in_valid = sparse ? (slot % 3 == 0) : 1'b1;
            if (in_valid) ld_q.push_back(3'(exp_ld[loaded]));
            half();
            chk("in_ready", in_ready, 1);
            chk("busy_load", busy, 1);
            chk("ld_we", ld_we, in_valid);
            step_edge();
            if (in_valid) loaded++;
        end
        in_valid = 1'b0;
        chk("ld_drain", ld_q.size(), 0);

        last_load = cyc_n;
        exp_done  = last_load + 3 * (4 + PL);
        for (int i = 0; i < 12; i++) begin
            e.st  = 2'(i / 4);
            e.a   = 3'(exp_a[i]);
            e.b   = 3'(exp_b[i]);
            e.tw  = 2'(exp_tw[i]);
            e.cyc = last_load + (i / 4) * (4 + PL) + (i % 4);
            bf_q.push_back(e);
        end

        for (int c = 0; c < 100; c++) begin
            start = poke && (c == 2 || cyc_n == exp_done);
            half();
            if (c == 0) chk("comp_entry", {bf_valid, stage}, {1'b1, 2'd0});
            if (abort_idx >= 0 && bf_valid === 1'b1 && issued == abort_idx) begin
                chk("abort_point", {stage, rd_addr_a, rd_addr_b}, {2'd1, 3'd4, 3'd6});
                start = 1'b0;
                rst_n = 1'b0;
                #1;
                chk("rst_async_outs", all_outs(), 0);
                bf_q.delete();
                wb_q.delete();
                aborted = 1'b1;
                return;
            end
            if (bf_valid === 1'b1) issued++;
            if (done === 1'b1) begin
                seen_done = 1'b1;
                chk("done_cycle", cyc_n, exp_done);
                chk("fin_busy", busy, 1);
            end else begin
                chk("busy_frame", busy, 1);
            end
            step_edge();
            if (seen_done) break;
        end
        if (!seen_done) chk("done_timeout", done, 1);

        start = 1'b0;
        half();
        chk("idle_after_done", {busy, done, in_ready}, 0);
        step_edge();
        half();
        chk("start_on_done_ignored", busy, 0);
        chk("bf_drain", bf_q.size(), 0);
        chk("wb_drain", wb_q.size(), 0);
        step_edge();
    endtask

    initial begin
        bit ab;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        half();
        chk("reset_outs", all_outs(), 0);
        step_edge();

        // Start in the same step as release: taken on the first edge
        rst_n = 1'b1;
        run_frame(1'b0, 1'b1, -1, ab);
        run_frame(1'b1, 1'b0, -1, ab);

        // Abort at stage 1, k=2
        run_frame(1'b0, 1'b0, 6, ab);
        chk("abort_reached", {30'd0, ab, 1'b0}, {30'd0, 1'b1, 1'b0});
        step_edge();
        half();
        chk("rst_hold_outs", all_outs(), 0);
        step_edge();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            half();
            chk("quiet_after_rst", {wr_en, busy, bf_valid}, 0);
            step_edge();
        end

        rst_n = 1'b0;
        step_edge();
        rst_n = 1'b1;
        run_frame(1'b0, 1'b0, -1, ab);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
